// File: rtl/mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit
//
// Instruction fetch stage of the mini MIPS core. Owns the PC, reads one
// instruction word at a time over a req/ready handshake, presents it to
// decode, then waits for execute to report branch resolution before
// choosing the next PC. Only one instruction is in flight at a time.
//
// Optional feature (compile-time macro MIPS_FETCH_PREFETCH_EN):
//   While an instruction sits in RESOLVE, the word at pc+1 is read into a
//   one-entry prefetch buffer so that a not-taken resolution can issue on
//   the very next cycle. A taken resolution discards the buffer; a read
//   still outstanding at that point is drained (DRAIN state) before the
//   branch target is fetched. With the macro undefined there is no buffer,
//   no DRAIN state, and imem_req is low in RESOLVE.
//
// Ports
//   clk, rst_n          rising-edge clock, async active-low reset
//   imem_req/imem_addr  read request and word address (stable while req=1)
//   imem_ready          read complete, imem_rdata valid this cycle
//   imem_rdata          instruction word from memory
//   instr_valid         instr/instr_pc/opcode are valid to decode
//   dec_ready           decode accepts the instruction this cycle
//   instr, instr_pc     issued instruction and its PC
//   opcode              top 4 bits of instr, feeds mips_control
//   ex_done             1-cycle pulse: issued instruction finished execute
//   ex_branch_eq/_not_eq, ex_zero, ex_offset
//                       branch resolution of that instruction (offset is
//                       a signed word count relative to pc+1)
// ---------------------------------------------------------------------------
module mips_fetch_unit #(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic [3:0]         opcode,
    input  logic               ex_done,
    input  logic               ex_branch_eq,
    input  logic               ex_branch_not_eq,
    input  logic               ex_zero,
    input  logic [15:0]        ex_offset
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_RESOLVE = 3'd3;
`ifdef MIPS_FETCH_PREFETCH_EN
    localparam logic [2:0] S_DRAIN   = 3'd4;
`endif

    logic [2:0]      state;
    logic [PC_W-1:0] pc;

    // Next-PC arithmetic. All sums wrap modulo 2^PC_W.
    logic            taken;
    logic [PC_W-1:0] offset_ext;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] next_pc;

    assign taken      = (ex_branch_eq & ex_zero) | (ex_branch_not_eq & ~ex_zero);
    assign offset_ext = PC_W'($signed(ex_offset));
    assign pc_inc     = pc + PC_W'(1);
    assign next_pc    = taken ? (pc_inc + offset_ext) : pc_inc;

    assign instr_valid = (state == S_ISSUE);
    assign opcode      = instr[INSTR_W-1 -: 4];

`ifdef MIPS_FETCH_PREFETCH_EN
    logic               pf_valid;
    logic [INSTR_W-1:0] pf_instr;
    logic [PC_W-1:0]    drain_addr;   // address of a prefetch abandoned by a taken branch
    logic               pf_fill;      // prefetch read completes this cycle
    logic               pf_hit;       // pc+1 word available now (buffered or arriving)
    logic [INSTR_W-1:0] pf_data;

    // A read completing in the same cycle as ex_done counts as done first,
    // so it is folded into the hit path rather than treated as outstanding.
    assign pf_fill = (state == S_RESOLVE) && !pf_valid && imem_ready;
    assign pf_hit  = pf_valid || pf_fill;
    assign pf_data = pf_valid ? pf_instr : imem_rdata;
`endif

    // Memory request side is a pure function of state, so imem_req drops in
    // the same instant an async reset forces IDLE.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned and no latch is inferred.
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            S_FETCH: imem_req = 1'b1;
`ifdef MIPS_FETCH_PREFETCH_EN
            S_RESOLVE: begin
                imem_req  = !pf_valid;
                imem_addr = pc_inc;
            end
            S_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            instr    <= '0;
            instr_pc <= '0;
`ifdef MIPS_FETCH_PREFETCH_EN
            pf_valid   <= 1'b0;
            pf_instr   <= '0;
            drain_addr <= RESET_PC;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below reads the pre-edge pc/state, not a partially
            // updated value.
            case (state)
                S_IDLE: state <= S_FETCH;

                S_FETCH: begin
                    if (imem_ready) begin
                        instr    <= imem_rdata;
                        instr_pc <= pc;
                        state    <= S_ISSUE;
                    end
                end

                // Leaving ISSUE on the first dec_ready guarantees exactly one
                // accept per instruction.
                S_ISSUE: begin
                    if (dec_ready) begin
                        state <= S_RESOLVE;
                    end
                end

                S_RESOLVE: begin
`ifdef MIPS_FETCH_PREFETCH_EN
                    if (ex_done) begin
                        pc       <= next_pc;
                        pf_valid <= 1'b0;
                        if (taken) begin
                            // Buffered or just-arrived word is wrong path.
                            drain_addr <= pc_inc;
                            state      <= pf_hit ? S_FETCH : S_DRAIN;
                        end else if (pf_hit) begin
                            instr    <= pf_data;
                            instr_pc <= pc_inc;
                            state    <= S_ISSUE;
                        end else begin
                            // Outstanding read at pc+1 carries on in FETCH,
                            // whose address (the new pc) is the same word.
                            state <= S_FETCH;
                        end
                    end else if (pf_fill) begin
                        pf_valid <= 1'b1;
                        pf_instr <= imem_rdata;
                    end
`else
                    if (ex_done) begin
                        pc    <= next_pc;
                        state <= S_FETCH;
                    end
`endif
                end

`ifdef MIPS_FETCH_PREFETCH_EN
                // Hold the abandoned request until memory completes it, then
                // drop the data and fetch the branch target.
                S_DRAIN: begin
                    if (imem_ready) begin
                        state <= S_FETCH;
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_unit
//
// Directed bench for mips_fetch_unit (PC_W=16, INSTR_W=32, RESET_PC=0).
// A memory model returns a word derived from its address after a
// programmable number of wait cycles. The bench tracks the PC of the next
// instruction that must issue using the branch rule on plain 16-bit
// arithmetic; a compare process checks every issued instruction against
// that PC and the memory contents, counts accepts, and checks that the
// request address stays put while a read is pending. Each directed step
// also pins the expected next PC with a hand-computed literal.
// Works in both builds; prefetch-specific expectations follow
// MIPS_FETCH_PREFETCH_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic [3:0]  opcode;
    logic        ex_done = 1'b0;
    logic        ex_branch_eq = 1'b0;
    logic        ex_branch_not_eq = 1'b0;
    logic        ex_zero = 1'b0;
    logic [15:0] ex_offset = '0;

    mips_fetch_unit #(
        .PC_W    (16),
        .INSTR_W (32),
        .RESET_PC(16'h0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .dec_ready       (dec_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .opcode          (opcode),
        .ex_done         (ex_done),
        .ex_branch_eq    (ex_branch_eq),
        .ex_branch_not_eq(ex_branch_not_eq),
        .ex_zero         (ex_zero),
        .ex_offset       (ex_offset)
    );

    always #5 clk = ~clk;

`ifdef MIPS_FETCH_PREFETCH_EN
    localparam int          FT_LAT     = 1;        // not-taken: issue from buffer
    localparam logic [15:0] POST_TAKEN = 16'h0002; // drain keeps the stale address
`else
    localparam int          FT_LAT     = 2;
    localparam logic [15:0] POST_TAKEN = 16'h0007; // straight to the target
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accepts = 0;
    int mem_lat = 0;
    bit ready_override = 1'b0;
    logic [15:0] exp_pc = 16'h0000;
    logic [15:0] last_req_addr = 16'hDEAD;

    // Memory contents: address 0 holds 0x1234_0000 (opcode 1); every word
    // is distinct and carries its own address in the low half.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a[3:0] ^ 4'h1, 12'h234, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: ready after mem_lat wait cycles of a held request.
    bit req_s = 1'b0;
    bit rdy_s = 1'b0;
    int wait_cnt = 0;
    initial forever begin
        @(negedge clk);
        req_s = rst_n && imem_req;
        rdy_s = imem_ready;
    end
    initial forever begin
        @(posedge clk);
        if (req_s && !rdy_s) wait_cnt++;
        else wait_cnt = 0;
        #2;
        imem_ready = ready_override || (imem_req && (wait_cnt >= mem_lat));
        imem_rdata = mem_word(imem_addr);
    end

    // Compare process: every issued cycle against the model PC.
    bit          prev_req = 1'b0;
    bit          prev_rdy = 1'b0;
    logic [15:0] prev_addr = '0;
    initial forever begin
        logic [31:0] w;
        @(negedge clk);
        if (rst_n) begin
            if (instr_valid) begin
                w = mem_word(exp_pc);
                check("issue_pc", 32'(instr_pc), 32'(exp_pc));
                check("issue_instr", instr, w);
                check("issue_opcode", 32'(opcode), 32'(w[31:28]));
                if (dec_ready) accepts++;
            end
            if (prev_req && !prev_rdy && imem_req)
                check("addr_hold", 32'(imem_addr), 32'(prev_addr));
            if (imem_req) last_req_addr = imem_addr;
        end
        prev_req  = rst_n && imem_req;
        prev_rdy  = imem_ready;
        prev_addr = imem_addr;
    end

    task automatic wait_valid(input string name, output int vcyc);
        vcyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                vcyc = cyc;
                break;
            end
        end
        checks++;
        if (vcyc < 0) begin
            errors++;
            $display("FAIL %s: instr_valid not seen within 60 cycles", name);
        end
    endtask

    // Accept the current instruction, then report its resolution.
    task automatic resolve_instr(input string name, input bit eq, input bit ne, input bit z,
                                 input logic [15:0] off, input int hold, input int rlen,
                                 input int rdelay, input bit spur, output int done_cyc);
        int acc0;
        bit tk;
        acc0 = accepts;
        if (spur) begin
            // Taken-looking ex_done while still in ISSUE must be ignored.
            @(posedge clk); #1;
            ex_done = 1'b1; ex_branch_eq = 1'b1; ex_zero = 1'b1; ex_offset = 16'h0010;
            @(posedge clk); #1;
            ex_done = 1'b0; ex_branch_eq = 1'b0; ex_zero = 1'b0; ex_offset = '0;
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1 dec_ready = 1'b1;
        repeat (rlen) @(posedge clk);
        #1 dec_ready = 1'b0;
        check({name, "_accepts"}, 32'(accepts - acc0), 32'd1);
        repeat (rdelay) begin
            @(posedge clk); #1;
        end
        ex_done = 1'b1; ex_branch_eq = eq; ex_branch_not_eq = ne; ex_zero = z; ex_offset = off;
        tk = (eq && z) || (ne && !z);
        exp_pc = tk ? (exp_pc + 16'd1 + off) : (exp_pc + 16'd1);
        done_cyc = cyc;
        @(posedge clk); #1;
        ex_done = 1'b0; ex_branch_eq = 1'b0; ex_branch_not_eq = 1'b0; ex_zero = 1'b0;
        ex_offset = '0;
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [15:0] nxt;
        bit          eq;
        bit          ne;
        bit          z;
        logic [15:0] off;
        int          hold;
        int          rlen;
        int          rdelay;
        bit          spur;
        int          lat;    // -1: latency not checked
    } step_t;

    step_t steps [12];

    initial begin
        int dc;
        int vc;
        string nm;

        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int vc;
        string nm;

        //            pc        next      eq ne z  off       hold rlen rdly spur lat
        steps[0]  = '{16'h0000, 16'h0001, 0, 0, 0, 16'h0000, 0,   1,   0,   0,   FT_LAT};
        steps[1]  = '{16'h0001, 16'h0002, 0, 0, 0, 16'h0000, 0,   1,   1,   0,   -1};
        steps[2]  = '{16'h0002, 16'h0004, 0, 1, 0, 16'h0001, 2,   1,   0,   0,   -1};
        steps[3]  = '{16'h0004, 16'h0002, 1, 0, 1, 16'hFFFD, 0,   1,   0,   0,   2};
        steps[4]  = '{16'h0002, 16'h0004, 0, 1, 0, 16'h0001, 0,   1,   2,   0,   -1};
        steps[5]  = '{16'h0004, 16'h0005, 1, 0, 0, 16'hFFFD, 0,   1,   0,   0,   -1};
        steps[6]  = '{16'h0005, 16'h0004, 1, 0, 1, 16'hFFFE, 1,   2,   0,   0,   -1};
        steps[7]  = '{16'h0004, 16'h0008, 0, 1, 0, 16'h0003, 0,   1,   0,   0,   -1};
        steps[8]  = '{16'h0008, 16'h0009, 0, 1, 1, 16'h0005, 0,   1,   0,   0,   -1};
        steps[9]  = '{16'h0009, 16'hFFFF, 1, 0, 1, 16'hFFF5, 0,   1,   0,   0,   -1};
        steps[10] = '{16'hFFFF, 16'h0000, 0, 0, 0, 16'h0000, 10,  3,   0,   1,   -1};
        steps[11] = '{16'h0000, 16'h0001, 0, 0, 0, 16'h0000, 0,   1,   3,   0,   FT_LAT};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'h0000);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", 32'(instr_pc), 32'h0000);
        check("rst_opcode", 32'(opcode), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // First fetch: word 0x1234_0000 from address 0.
        wait_valid("first_issue", vc);
        check("first_req_addr", 32'(last_req_addr), 32'h0000);
        check("first_instr", instr, 32'h1234_0000);
        check("first_opcode", 32'(opcode), 32'h1);
        check("first_pc", 32'(instr_pc), 32'h0000);

        // Sequential, branch and wrap steps on zero-wait memory.
        foreach (steps[i]) begin
            nm = $sformatf("step%0d", i);
            check({nm, "_pc"}, 32'(instr_pc), 32'(steps[i].pc));
            resolve_instr(nm, steps[i].eq, steps[i].ne, steps[i].z, steps[i].off,
                          steps[i].hold, steps[i].rlen, steps[i].rdelay, steps[i].spur, dc);
            wait_valid(nm, vc);
            check({nm, "_next"}, 32'(instr_pc), 32'(steps[i].nxt));
            if (steps[i].lat >= 0) check({nm, "_lat"}, 32'(vc - dc), 32'(steps[i].lat));
            if (i == 10) check("wrap_req_addr", 32'(last_req_addr), 32'h0000);
        end

        // Taken branch while a 3-cycle read is outstanding.
        mem_lat = 3;
        resolve_instr("slow_taken", 1'b1, 1'b0, 1'b1, 16'h0005, 0, 1, 0, 1'b0, dc);
        @(negedge clk);
        check("post_taken_req", 32'(imem_req), 32'd1);
        check("post_taken_addr", 32'(imem_addr), 32'(POST_TAKEN));
        wait_valid("slow_taken", vc);
        check("slow_taken_next", 32'(instr_pc), 32'h0007);

        // Not-taken with a slow read still in progress.
        resolve_instr("slow_ft", 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1, 0, 1'b0, dc);
        wait_valid("slow_ft", vc);
        check("slow_ft_next", 32'(instr_pc), 32'h0008);

        // Reset in the middle of a fetch, late ready afterwards.
        mem_lat = 6;
        resolve_instr("mid_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1, 0, 1'b0, dc);
        @(negedge clk);
        check("mid_fetch_req", 32'(imem_req), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_pc = 16'h0000;
        @(negedge clk);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_addr", 32'(imem_addr), 32'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_override = 1'b1;
        @(negedge clk);
        check("late_ready_valid", 32'(instr_valid), 32'd0);
        check("late_ready_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        ready_override = 1'b0;
        mem_lat = 0;
        wait_valid("refetch", vc);
        check("refetch_pc", 32'(instr_pc), 32'h0000);
        check("refetch_addr", 32'(last_req_addr), 32'h0000);
        check("refetch_opcode", 32'(opcode), 32'h1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
